booth_mul_seq: RTL

- Multi-cycle sequencer for signed 32x32 radix-2 Booth multiplication in the EX stage of the pipelined MIPS core.
- Accepts an operand pair from EX, stalls the pipeline while it iterates, then presents a 64-bit product (HI/LO).
- Drives the select of the EX writeback 2:1 mux, which chooses between the ALU result and the multiplier result.

---
 rtl/mul_pkg.sv | 15 +
 rtl/booth_step.sv | 29 ++
 rtl/booth_mul_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic WB_ALU = 1'b0;
   localparam logic WB_MUL = 1'b1;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic shift of {A,Q,q_m1}.
module booth_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_m1_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = a;
      case ({q[0], q_m1})
         2'b01:   sum = a + m;
         2'b10:   sum = a - m;
         default: sum = a;
      endcase
   end

   assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
   assign q_next    = {sum[0], q[WIDTH-1:1]};
   assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle signed Booth multiplier for the EX stage; stalls the pipeline while iterating
// and steers the EX writeback mux to the product for the single completion cycle.
//
// state | meaning
// IDLE  | waiting for start; a held start stalls EX in the request cycle
// RUN   | WIDTH Booth iterations, pipeline stalled
// DONE  | one cycle: product valid, done and wb_sel high, stall released
module booth_mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             wb_sel,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, m_q, a_next;
   logic [WIDTH-1:0] q_q, q_next;
   logic             q_m1_q, q_m1_next;
   logic [CNT_W-1:0] cnt_q;
   logic             accept, last_iter;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a         (a_q),
      .q         (q_q),
      .q_m1      (q_m1_q),
      .m         (m_q),
      .a_next    (a_next),
      .q_next    (q_next),
      .q_m1_next (q_m1_next)
   );

   assign accept    = (state_q == IDLE) && start && !flush;
   assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(1)) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // flush beats both acceptance and completion
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         q_q     <= '0;
         q_m1_q  <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         prod_hi <= '0;
         prod_lo <= '0;
      end else begin
         if (accept) begin
            a_q    <= '0;
            q_q    <= mplier;
            q_m1_q <= 1'b0;
            m_q    <= {mcand[WIDTH-1], mcand};
            cnt_q  <= CNT_W'(WIDTH);
         end else if (state_q == RUN && !flush) begin
            a_q    <= a_next;
            q_q    <= q_next;
            q_m1_q <= q_m1_next;
            cnt_q  <= cnt_q - CNT_W'(1);
         end
         if (last_iter) begin
            prod_hi <= a_next[WIDTH-1:0];
            prod_lo <= q_next;
         end
      end
   end

   assign busy   = (state_q == RUN) || (state_q == DONE);
   assign stall  = (state_q == RUN) || ((state_q == IDLE) && start);
   assign done   = (state_q == DONE) && !flush;
   assign wb_sel = done ? WB_MUL : WB_ALU;

endmodule
